// File: rtl/mmio_uart_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_counter_pkg
//  Description : MMIO address map and UART read-select encodings.
//  Revision    : 1.0
// ============================================================================
package mmio_uart_counter_pkg;

  localparam logic [31:0] ADDR_UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] ADDR_UART_RX   = 32'h8000_0004;
  localparam logic [31:0] ADDR_UART_TX   = 32'h8000_0008;
  localparam logic [31:0] ADDR_UART_RD   = 32'h8000_000c;
  localparam logic [31:0] ADDR_CYCLE_CNT = 32'h8000_0010;
  localparam logic [31:0] ADDR_INSTR_CNT = 32'h8000_0014;
  localparam logic [31:0] ADDR_CNT_RESET = 32'h8000_0018;

  typedef enum logic [1:0] {
    UART_RX_DATA = 2'b00,
    UART_TX_RDY  = 2'b01,
    UART_RX_VLD  = 2'b10,
    UART_BIOS    = 2'b11
  } uart_sel_e;

  function automatic logic [31:0] status_word(input logic flag);
    return {31'b0, flag};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_counter_if
//  Description : CPU-side MMIO controls plus UART byte handshakes.
//  Revision    : 1.0
// ============================================================================
interface mmio_uart_counter_if;
  import mmio_uart_counter_pkg::*;

  logic        we_uart;
  logic        re_uart;
  uart_sel_e   uart_sel;
  logic        ct_sel;
  logic        ct_reset;
  logic        instr_retire;
  logic [31:0] store_data;
  logic [31:0] bios_dout;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [31:0] uart_rdata;
  logic [31:0] ct_rdata;

  modport slave (
    input  we_uart, re_uart, uart_sel, ct_sel, ct_reset, instr_retire,
    input  store_data, bios_dout, uart_tx_ready, uart_rx_data, uart_rx_valid,
    output uart_tx_data, uart_tx_valid, uart_rx_ready, uart_rdata, ct_rdata
  );

  modport master (
    output we_uart, re_uart, uart_sel, ct_sel, ct_reset, instr_retire,
    output store_data, bios_dout, uart_tx_ready, uart_rx_data, uart_rx_valid,
    input  uart_tx_data, uart_tx_valid, uart_rx_ready, uart_rdata, ct_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mmio_uart_counter_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Pointer-based circular FIFO with occupancy count register.
//  Revision    : 1.0
// ============================================================================
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push into a full FIFO is legal alongside it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_counter
//  Description : UART TX FIFO / RX holding register, cycle+instruction counters,
//                registered MMIO read data.
//  Revision    : 1.0
// ============================================================================
module mmio_uart_counter
  import mmio_uart_counter_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_uart_counter_if.slave   bus
);

  localparam int FIFO_CNT_W = $clog2(TX_DEPTH) + 1;

  logic                  tx_full;
  logic                  tx_empty;
  logic                  tx_pop;
  logic [7:0]            tx_head;
  logic [FIFO_CNT_W-1:0] tx_count;
  logic                  tx_drop_q, tx_drop_d;

  logic                  rx_full_q, rx_full_d;
  logic [7:0]            rx_byte_q, rx_byte_d;
  logic                  rx_accept;

  logic [CNT_W-1:0]      cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]      instr_cnt_q, instr_cnt_d;

  logic [31:0]           uart_rdata_q, uart_rdata_d;
  logic [31:0]           ct_rdata_q, ct_rdata_d;

  assign tx_pop = ~tx_empty & bus.uart_tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.we_uart),
    .pop_i   (tx_pop),
    .wdata_i (bus.store_data[7:0]),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  assign bus.uart_tx_data  = tx_head;
  assign bus.uart_tx_valid = ~tx_empty;
  assign bus.uart_rx_ready = ~rx_full_q;
  assign bus.uart_rdata    = uart_rdata_q;
  assign bus.ct_rdata      = ct_rdata_q;

  assign rx_accept = bus.uart_rx_valid & ~rx_full_q;

  always_comb begin
    tx_drop_d   = tx_drop_q | (bus.we_uart & tx_full & ~tx_pop);
    rx_full_d   = rx_full_q;
    rx_byte_d   = rx_byte_q;
    // While full, ready is low, so a byte arriving with re_uart waits a cycle.
    if (rx_accept) begin
      rx_full_d = 1'b1;
      rx_byte_d = bus.uart_rx_data;
    end else if (bus.re_uart) begin
      rx_full_d = 1'b0;
    end

    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    instr_cnt_d = instr_cnt_q + CNT_W'(bus.instr_retire);
    if (bus.ct_reset) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end
  end

  always_comb begin
    uart_rdata_d = '0;
    unique case (bus.uart_sel)
      UART_RX_DATA: uart_rdata_d = {24'b0, rx_byte_q};
      UART_TX_RDY:  uart_rdata_d = status_word(~tx_full);
      UART_RX_VLD:  uart_rdata_d = status_word(rx_full_q);
      UART_BIOS:    uart_rdata_d = bus.bios_dout;
      default:      uart_rdata_d = '0;
    endcase
    ct_rdata_d = bus.ct_sel ? 32'(instr_cnt_q) : 32'(cycle_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_drop_q    <= 1'b0;
      rx_full_q    <= 1'b0;
      rx_byte_q    <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      uart_rdata_q <= '0;
      ct_rdata_q   <= '0;
    end else begin
      tx_drop_q    <= tx_drop_d;
      rx_full_q    <= rx_full_d;
      rx_byte_q    <= rx_byte_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      uart_rdata_q <= uart_rdata_d;
      ct_rdata_q   <= ct_rdata_d;
    end
  end

  // Store bits above the byte lane, the FIFO depth and the sticky drop flag are debug-only.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.store_data[31:8], tx_count, tx_drop_q};

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_counter
//  Description : Directed + random stimulus against a queue-based reference model.
//  Revision    : 1.0
// ============================================================================
module tb_mmio_uart_counter;
  import mmio_uart_counter_pkg::*;

  logic clk = 1'b0;
  logic reset;

  mmio_uart_counter_if bus();

  mmio_uart_counter #(
    .TX_DEPTH (4),
    .CNT_W    (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_ct  = 1'b1;

  // Reference model state
  byte unsigned m_txq[$];
  bit           m_drop;
  bit           m_rx_full;
  logic [7:0]   m_rx_byte;
  logic [31:0]  m_cyc, m_ins, m_urd, m_crd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic model_edge();
    bit full;
    bit pop;
    if (reset) begin
      m_txq.delete();
      m_drop = 0; m_rx_full = 0; m_rx_byte = '0;
      m_cyc = '0; m_ins = '0; m_urd = '0; m_crd = '0;
    end else begin
      full = (m_txq.size() == 4);
      pop  = (m_txq.size() != 0) && bus.uart_tx_ready;
      case (bus.uart_sel)
        UART_RX_DATA: m_urd = {24'b0, m_rx_byte};
        UART_TX_RDY:  m_urd = {31'b0, !full};
        UART_RX_VLD:  m_urd = {31'b0, m_rx_full};
        default:      m_urd = bus.bios_dout;
      endcase
      m_crd = bus.ct_sel ? m_ins : m_cyc;
      if (pop) void'(m_txq.pop_front());
      if (bus.we_uart) begin
        if (!full || pop) m_txq.push_back(bus.store_data[7:0]);
        else m_drop = 1;
      end
      if (!m_rx_full && bus.uart_rx_valid) begin
        m_rx_byte = bus.uart_rx_data;
        m_rx_full = 1;
      end else if (bus.re_uart) begin
        m_rx_full = 0;
      end
      if (bus.ct_reset) begin
        m_cyc = '0;
        m_ins = '0;
      end else begin
        m_cyc = m_cyc + 32'd1;
        m_ins = m_ins + 32'(bus.instr_retire);
      end
    end
  endtask

  task automatic check_outputs();
    chk("tx_valid", 32'(bus.uart_tx_valid), 32'(m_txq.size() != 0));
    if (m_txq.size() != 0) chk("tx_data", 32'(bus.uart_tx_data), 32'(m_txq[0]));
    chk("rx_ready", 32'(bus.uart_rx_ready), 32'(!m_rx_full));
    chk("uart_rdata", bus.uart_rdata, m_urd);
    if (chk_ct) chk("ct_rdata", bus.ct_rdata, m_crd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    bus.we_uart       = 1'b0;
    bus.re_uart       = 1'b0;
    bus.uart_sel      = UART_RX_DATA;
    bus.ct_sel        = 1'b0;
    bus.ct_reset      = 1'b0;
    bus.instr_retire  = 1'b0;
    bus.store_data    = '0;
    bus.bios_dout     = 32'hB105_0000;
    bus.uart_tx_ready = 1'b0;
    bus.uart_rx_data  = '0;
    bus.uart_rx_valid = 1'b0;
  endtask

  initial begin
    byte unsigned got[$];
    logic [31:0]  s[8];

    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_tx_drop", 32'(dut.tx_drop_q), 32'd0);
    chk("reset_ct_rdata", bus.ct_rdata, 32'd0);

    // 1: three queued bytes, then drain in order
    bus.uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.we_uart = 1'b1;
      bus.store_data = 32'hFFFF_FF41 + 32'(i);
      tick();
    end
    bus.we_uart  = 1'b0;
    bus.uart_sel = UART_TX_RDY;
    tick();
    chk("t1_valid", 32'(bus.uart_tx_valid), 32'd1);
    chk("t1_head", 32'(bus.uart_tx_data), 32'h41);
    chk("t1_status", bus.uart_rdata, 32'd1);
    bus.uart_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.uart_tx_valid) got.push_back(bus.uart_tx_data);
      tick();
    end
    chk("t1_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < got.size(); i++) chk("t1_order", 32'(got[i]), 32'h41 + 32'(i));
    chk("t1_valid_drop", 32'(bus.uart_tx_valid), 32'd0);

    // 2: overflow, then push+pop on a full FIFO
    bus.uart_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.we_uart = 1'b1;
      bus.store_data = 32'h10 + 32'(i);
      tick();
    end
    bus.we_uart = 1'b0;
    tick();
    chk("t2_status_full", bus.uart_rdata, 32'd0);
    chk("t2_tx_drop", 32'(dut.tx_drop_q), 32'd1);
    bus.we_uart = 1'b1;
    bus.store_data = 32'h99;
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.we_uart = 1'b0;
    bus.uart_tx_ready = 1'b0;
    chk("t2_count_full", 32'(dut.u_tx_fifo.count_q), 32'd4);
    chk("t2_head_after", 32'(bus.uart_tx_data), 32'h11);
    bus.uart_tx_ready = 1'b1;
    repeat (5) tick();
    bus.uart_tx_ready = 1'b0;

    // 3: RX holding register
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = 8'h5A;
    tick();
    bus.uart_rx_valid = 1'b0;
    chk("t3_rx_ready_low", 32'(bus.uart_rx_ready), 32'd0);
    bus.uart_sel = UART_RX_VLD;
    tick();
    chk("t3_rx_vld", bus.uart_rdata, 32'd1);
    bus.uart_sel = UART_RX_DATA;
    tick();
    chk("t3_rx_data", bus.uart_rdata, 32'h5A);
    bus.re_uart = 1'b1;
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = 8'h33;
    tick();
    bus.re_uart = 1'b0;
    tick();
    bus.uart_rx_valid = 1'b0;
    tick();
    chk("t3_rx_late", bus.uart_rdata, 32'h33);
    bus.re_uart = 1'b1;
    tick();
    bus.re_uart = 1'b0;

    // 4: counters over 100 cycles, retire on alternate cycles
    bus.ct_reset = 1'b1;
    tick();
    bus.ct_reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.instr_retire = (i % 2 == 0);
      tick();
    end
    bus.instr_retire = 1'b0;
    bus.ct_sel = 1'b0;
    tick();
    chk("t4_cycles", bus.ct_rdata, 32'd100);
    bus.ct_sel = 1'b1;
    tick();
    chk("t4_instrs", bus.ct_rdata, 32'd50);
    bus.ct_reset = 1'b1;
    tick();
    bus.ct_reset = 1'b0;
    bus.ct_sel = 1'b0;
    tick();
    chk("t4_ct_reset", bus.ct_rdata, 32'd0);

    // 5: wrap from near all-ones, then ct_reset alongside instr_retire
    chk_ct = 1'b0;
    bus.ct_sel = 1'b0;
    force dut.cycle_cnt_q = 32'hFFFF_FFFC;
    tick();
    release dut.cycle_cnt_q;
    for (int i = 0; i < 8; i++) begin
      tick();
      s[i] = bus.ct_rdata;
    end
    chk("t5_before_wrap", 32'(s[0] >= 32'hFFFF_FFF0), 32'd1);
    chk("t5_after_wrap", 32'(s[7] < 32'd16), 32'd1);
    chk("t5_wrap_step", s[7] - s[0], 32'd7);
    bus.ct_reset = 1'b1;
    bus.instr_retire = 1'b1;
    tick();
    bus.ct_reset = 1'b0;
    bus.instr_retire = 1'b0;
    bus.ct_sel = 1'b1;
    chk_ct = 1'b1;
    tick();
    chk("t5_instr_zero", bus.ct_rdata, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset             = ($urandom_range(0, 63) == 0);
      bus.we_uart       = $urandom_range(0, 1) == 1;
      bus.re_uart       = ($urandom_range(0, 3) == 0);
      bus.uart_sel      = uart_sel_e'(2'($urandom_range(0, 3)));
      bus.ct_sel        = $urandom_range(0, 1) == 1;
      bus.ct_reset      = ($urandom_range(0, 31) == 0);
      bus.instr_retire  = $urandom_range(0, 1) == 1;
      bus.store_data    = $urandom;
      bus.bios_dout     = $urandom;
      bus.uart_tx_ready = $urandom_range(0, 2) == 0;
      bus.uart_rx_data  = 8'($urandom);
      bus.uart_rx_valid = $urandom_range(0, 1) == 1;
      tick();
    end
    reset = 1'b0;
    idle();

    // 6: reset with bytes buffered and RX held
    for (int i = 0; i < 2; i++) begin
      bus.we_uart = 1'b1;
      bus.store_data = 32'hA0 + 32'(i);
      tick();
    end
    bus.we_uart = 1'b0;
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data = 8'hC3;
    tick();
    bus.uart_rx_valid = 1'b0;
    bus.uart_sel = UART_BIOS;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_tx_valid", 32'(bus.uart_tx_valid), 32'd0);
    chk("t6_rx_ready", 32'(bus.uart_rx_ready), 32'd1);
    chk("t6_uart_rdata", bus.uart_rdata, 32'd0);
    chk("t6_ct_rdata", bus.ct_rdata, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
